// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory request arbiter.
// Contents:
//   STARVE_LIMIT_DEFAULT - default number of consecutive D-port grants that a
//                          waiting I-port request tolerates before it wins
//   arb_state_t          - arbiter FSM state encoding
//   fwd_ren()            - read strobe forwarded downstream (a write wins
//                          when a requester raises both strobes together)
package mem_arb_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_t;

  function automatic logic fwd_ren(input logic ren, input logic wen);
    return ren & ~wen;
  endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant selection between the I (icache) and D (dcache) ports.
// Ports:
//   i_req, d_req  in   port requests (ren | wen)
//   starve_cnt    in   consecutive D grants made while I was waiting
//   grant_i       out  I wins this arbitration
//   grant_d       out  D wins this arbitration
// D has priority, except that a starved I port (counter at the limit) wins.
module arb_grant_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_i,
  output logic             grant_d
);

  logic starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Pick the winner; at most one grant is ever high.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req && (!d_req || starved)) begin
      grant_i = 1'b1;
    end else if (d_req) begin
      grant_d = 1'b1;
    end else begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-port (icache / dcache) to single downstream bus request arbiter.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   i_* / d_*                    requester side: addr, wdata, byte_en, ren,
//                                wen in; rdata, busy out
//   out_addr/wdata/byte_en/ren/wen  registered downstream request
//   out_rdata, out_busy          downstream response; out_busy low = done
// One transaction is in flight at a time; every transaction is followed by
// at least one IDLE cycle before the next arbitration.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic                i_ren,
  input  logic                i_wen,
  input  logic [DATA_W/8-1:0] i_byte_en,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_busy,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic                d_ren,
  input  logic                d_wen,
  input  logic [DATA_W/8-1:0] d_byte_en,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_busy,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [DATA_W/8-1:0] out_byte_en,
  output logic                out_ren,
  output logic                out_wen,
  input  logic [DATA_W-1:0]   out_rdata,
  input  logic                out_busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t          state_q, state_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] byte_en_q, byte_en_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;

  logic i_req, d_req;
  logic grant_i, grant_d;

  assign i_req = i_ren | i_wen;
  assign d_req = d_ren | d_wen;

  arb_grant_sel #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_grant_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt_q),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  // Next-state, starvation counter and request-latch logic.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    byte_en_d    = byte_en_q;
    ren_d        = ren_q;
    wen_d        = wen_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_i) begin
          state_d      = ST_GRANT_I;
          addr_d       = i_addr;
          wdata_d      = i_wdata;
          byte_en_d    = i_byte_en;
          ren_d        = fwd_ren(i_ren, i_wen);
          wen_d        = i_wen;
          starve_cnt_d = {CNT_W{1'b0}};
        end else if (grant_d) begin
          state_d   = ST_GRANT_D;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          byte_en_d = d_byte_en;
          ren_d     = fwd_ren(d_ren, d_wen);
          wen_d     = d_wen;
          // Only D wins that leave I waiting count toward starvation.
          if (!i_req) begin
            starve_cnt_d = {CNT_W{1'b0}};
          end else if (starve_cnt_q == CNT_LIMIT) begin
            starve_cnt_d = starve_cnt_q;
          end else begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else begin
          starve_cnt_d = {CNT_W{1'b0}};
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        // The latched request stays put until the downstream completes,
        // even if the requester has already withdrawn.
        if (!out_busy) begin
          state_d = ST_IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
      end
    endcase
  end

  // State and downstream request registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= {CNT_W{1'b0}};
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      byte_en_q    <= {(DATA_W/8){1'b0}};
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      byte_en_q    <= byte_en_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
    end
  end

  assign out_addr    = addr_q;
  assign out_wdata   = wdata_q;
  assign out_byte_en = byte_en_q;
  assign out_ren     = ren_q;
  assign out_wen     = wen_q;

  // Requester-side busy and read-data return. Busy tracks the raw request
  // so it rises in the same cycle as the request; it drops for the granted
  // port only in the completion cycle. A withdrawn request gets no data.
  always_comb begin
    i_busy  = 1'b0;
    d_busy  = 1'b0;
    i_rdata = {DATA_W{1'b0}};
    d_rdata = {DATA_W{1'b0}};
    if (RST) begin
      i_busy  = 1'b0;
      d_busy  = 1'b0;
      i_rdata = {DATA_W{1'b0}};
      d_rdata = {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_GRANT_I: begin
          i_busy  = i_req & out_busy;
          i_rdata = (i_req && !out_busy) ? out_rdata : {DATA_W{1'b0}};
          d_busy  = d_req;
        end
        ST_GRANT_D: begin
          d_busy  = d_req & out_busy;
          d_rdata = (d_req && !out_busy) ? out_rdata : {DATA_W{1'b0}};
          i_busy  = i_req;
        end
        ST_IDLE: begin
          i_busy = i_req;
          d_busy = d_req;
        end
        default: begin
          i_busy = i_req;
          d_busy = d_req;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios followed by a
// randomized phase, all checked every cycle against a transaction-level
// reference model (current owner, D-win streak, latched request record).
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int LIM = 4;

  logic        CLK, RST;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_ren, i_wen, d_ren, d_wen;
  logic [3:0]  i_byte_en, d_byte_en;
  logic [31:0] i_rdata, d_rdata;
  logic        i_busy, d_busy;
  logic [31:0] out_addr, out_wdata, out_rdata;
  logic [3:0]  out_byte_en;
  logic        out_ren, out_wen, out_busy;

  mem_req_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_ren(i_ren), .i_wen(i_wen),
    .i_byte_en(i_byte_en), .i_rdata(i_rdata), .i_busy(i_busy),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ren(d_ren), .d_wen(d_wen),
    .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_busy(d_busy),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_byte_en(out_byte_en),
    .out_ren(out_ren), .out_wen(out_wen), .out_rdata(out_rdata),
    .out_busy(out_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = nobody owns the bus, 1 = I, 2 = D.
  int          m_owner;
  int          m_streak;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ren, m_wen;
  logic        e_ib, e_db;
  logic [31:0] e_ird, e_drd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model update for one rising edge, from the inputs applied before it.
  task automatic model_edge();
    logic ir, dr;
    ir = i_ren | i_wen;
    dr = d_ren | d_wen;
    if (RST) begin
      m_owner = 0; m_streak = 0;
      m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0; m_ren = 1'b0; m_wen = 1'b0;
    end else if (m_owner == 0) begin
      if (ir && (!dr || m_streak == LIM)) begin
        m_owner = 1; m_streak = 0;
        m_addr = i_addr; m_wdata = i_wdata; m_be = i_byte_en;
        m_ren = i_ren && !i_wen; m_wen = i_wen;
      end else if (dr) begin
        m_owner = 2;
        m_streak = ir ? ((m_streak + 1 > LIM) ? LIM : m_streak + 1) : 0;
        m_addr = d_addr; m_wdata = d_wdata; m_be = d_byte_en;
        m_ren = d_ren && !d_wen; m_wen = d_wen;
      end else begin
        m_streak = 0;
      end
    end else if (!out_busy) begin
      m_owner = 0; m_ren = 1'b0; m_wen = 1'b0;
    end
  endtask

  // Mid-cycle check of every output against the model.
  task automatic sample();
    logic ir, dr;
    @(negedge CLK);
    ir = i_ren | i_wen;
    dr = d_ren | d_wen;
    e_ib = 1'b0; e_db = 1'b0; e_ird = 32'h0; e_drd = 32'h0;
    if (!RST) begin
      e_ib = ir; e_db = dr;
      if (m_owner == 1 && !out_busy) begin
        e_ib = 1'b0;
        if (ir) e_ird = out_rdata;
      end
      if (m_owner == 2 && !out_busy) begin
        e_db = 1'b0;
        if (dr) e_drd = out_rdata;
      end
    end
    chk("out_ren", out_ren, m_ren);
    chk("out_wen", out_wen, m_wen);
    chk("out_addr", out_addr, m_addr);
    chk("out_wdata", out_wdata, m_wdata);
    chk("out_byte_en", out_byte_en, m_be);
    chk("i_busy", i_busy, e_ib);
    chk("d_busy", d_busy, e_db);
    chk("i_rdata", i_rdata, e_ird);
    chk("d_rdata", d_rdata, e_drd);
    chk("starve_cnt", dut.starve_cnt_q, m_streak);
  endtask

  task automatic advance();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic set_i(input logic ren, input logic wen, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    i_ren = ren; i_wen = wen; i_addr = a; i_wdata = wd; i_byte_en = be;
  endtask

  task automatic set_d(input logic ren, input logic wen, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    d_ren = ren; d_wen = wen; d_addr = a; d_wdata = wd; d_byte_en = be;
  endtask

  // Withdraw everything and let any transaction finish (bounded).
  task automatic drain();
    i_ren = 1'b0; i_wen = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    out_busy = 1'b0; RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      advance();
    end
    sample();
    chk("drain_idle", dut.state_q, ST_IDLE);
    advance();
  endtask

  logic       i_done, d_done;
  logic [1:0] rw;

  initial begin
    m_owner = 0; m_streak = 0;
    m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0; m_ren = 1'b0; m_wen = 1'b0;
    RST = 1'b1; out_busy = 1'b1; out_rdata = 32'h0;
    set_i(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    set_d(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    advance();
    // Reset cycle: requests present but busy/rdata forced low.
    sample();
    chk("rst_i_busy", i_busy, 1'b0);
    chk("rst_out_ren", out_ren, 1'b0);
    advance();
    drain();

    // Single I read of 0x100, completion on the 2nd grant cycle.
    set_i(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    out_busy = 1'b1; out_rdata = 32'hDEADBEEF;
    sample();
    chk("ird_c0_busy", i_busy, 1'b1);
    chk("ird_c0_ren", out_ren, 1'b0);
    advance();
    sample();
    chk("ird_c1_ren", out_ren, 1'b1);
    chk("ird_c1_addr", out_addr, 32'h100);
    advance();
    out_busy = 1'b0;
    sample();
    chk("ird_c2_busy", i_busy, 1'b0);
    chk("ird_c2_rdata", i_rdata, 32'hDEADBEEF);
    advance();
    i_ren = 1'b0;
    sample();
    chk("ird_c3_ren", out_ren, 1'b0);
    advance();
    drain();

    // Both request from idle: D first, then I.
    set_i(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    set_d(1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    out_busy = 1'b0; out_rdata = 32'h12345678;
    sample();
    advance();
    sample();
    chk("both_first_addr", out_addr, 32'h300);
    chk("both_first_cnt", dut.starve_cnt_q, 32'd1);
    advance();
    d_ren = 1'b0;
    sample();
    advance();
    sample();
    chk("both_second_addr", out_addr, 32'h200);
    chk("both_second_cnt", dut.starve_cnt_q, 32'd0);
    advance();
    drain();

    // Starvation: D continuous, I held; 5th arbitration goes to I.
    set_i(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    set_d(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    out_busy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sample();
      advance();
      sample();
      if (k < 5) begin
        chk("starve_d_addr", out_addr, 32'h500);
        chk("starve_d_cnt", dut.starve_cnt_q, k);
      end else begin
        chk("starve_i_addr", out_addr, 32'h400);
        chk("starve_i_cnt", dut.starve_cnt_q, 32'd0);
      end
      advance();
    end
    drain();

    // D raises ren and wen together: only the write goes out.
    set_d(1'b1, 1'b1, 32'h40, 32'h55AA, 4'b0011);
    out_busy = 1'b0;
    sample();
    advance();
    sample();
    chk("rw_out_wen", out_wen, 1'b1);
    chk("rw_out_ren", out_ren, 1'b0);
    chk("rw_out_wdata", out_wdata, 32'h55AA);
    chk("rw_out_be", out_byte_en, 4'b0011);
    chk("rw_out_addr", out_addr, 32'h40);
    advance();
    drain();

    // Reset pulsed while D's transaction is stalled downstream.
    set_d(1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
    out_busy = 1'b1;
    sample();
    advance();
    sample();
    chk("rstmid_ren", out_ren, 1'b1);
    advance();
    RST = 1'b1;
    sample();
    chk("rstmid_d_busy", d_busy, 1'b0);
    chk("rstmid_d_rdata", d_rdata, 32'h0);
    advance();
    RST = 1'b0;
    sample();
    chk("rstmid_after_ren", out_ren, 1'b0);
    chk("rstmid_after_wen", out_wen, 1'b0);
    chk("rstmid_after_busy", d_busy, 1'b1);
    chk("rstmid_after_state", dut.state_q, ST_IDLE);
    advance();
    drain();

    // I withdraws mid-grant: transaction still completes, nothing reported.
    set_i(1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
    out_busy = 1'b1; out_rdata = 32'hCAFEF00D;
    sample();
    advance();
    advance();
    i_ren = 1'b0;
    sample();
    chk("drop_hold_ren", out_ren, 1'b1);
    chk("drop_hold_busy", i_busy, 1'b0);
    advance();
    out_busy = 1'b0;
    sample();
    chk("drop_done_ren", out_ren, 1'b1);
    chk("drop_done_rdata", i_rdata, 32'h0);
    advance();
    sample();
    chk("drop_idle_ren", out_ren, 1'b0);
    advance();
    drain();

    // Randomized traffic with occasional withdrawals and reset pulses.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_busy  = ($urandom_range(0, 2) == 0);
      out_rdata = $urandom();
      RST       = ($urandom_range(0, 99) == 0);
      sample();
      i_done = (i_ren | i_wen) & ~e_ib;
      d_done = (d_ren | d_wen) & ~e_db;
      advance();
      if (i_ren | i_wen) begin
        if (i_done || $urandom_range(0, 39) == 0) begin
          i_ren = 1'b0; i_wen = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        rw = 2'($urandom_range(1, 3));
        set_i(rw[0], rw[1], $urandom(), $urandom(), 4'($urandom()));
      end
      if (d_ren | d_wen) begin
        if (d_done || $urandom_range(0, 39) == 0) begin
          d_ren = 1'b0; d_wen = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        rw = 2'($urandom_range(1, 3));
        set_d(rw[0], rw[1], $urandom(), $urandom(), 4'($urandom()));
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
